// File: rtl/robot_pkg.sv
// Shared definitions for the wall-following cleaning robot controller.
// Holds the state encoding (also driven out on state_dbg) and the default
// timing parameters, so the controller and its bench agree on both.
package robot_pkg;

  // The numeric values are visible on state_dbg, so they are pinned explicitly.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WALK   = 3'd1,
    S_TURN_R = 3'd2,
    S_TURN_L = 3'd3,
    S_STEP   = 3'd4,
    S_CLEAN  = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam int TURN_CYCLES_DEF = 16;
  localparam int STEP_CYCLES_DEF = 32;
  localparam int CLEAN_MIN_DEF   = 8;
  localparam int CLEAN_MAX_DEF   = 255;

  // States in which the phase counter advances.
  function automatic logic is_timed(state_t s);
    return (s == S_TURN_R) || (s == S_TURN_L) || (s == S_STEP) || (s == S_CLEAN);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// 8-bit phase counter shared by all timed states of the robot controller.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  synchronous, active-low; clears the count
//   clear  in  zero the count (asserted on the edge that enters a new state)
//   enable in  advance the count by one, saturating at 255
//   last   in  terminal value; done is high while count equals it
//   count  out current phase count (0 on the first cycle of a state)
//   done   out count == last
module phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] last,
  output logic [7:0] count,
  output logic       done
);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      count <= 8'd0;
    end else if (enable && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  // A state lasting N cycles sees counts 0..N-1, so last is programmed as N-1.
  assign done = (count == last);

endmodule

// File: rtl/robot_controller.sv
// Wall-following cleaning robot controller: a Moore FSM that walks along a
// left-hand wall, turns away from frontal obstacles, steps forward after a
// left turn, and stops to remove trash, flagging a fault if cleaning hangs.
// Ports:
//   clk        in  clock, rising edge
//   reset      in  synchronous, active-low
//   head       in  front obstacle sensor (1 = obstacle)
//   left       in  left wall sensor (1 = wall present)
//   under      in  trash sensor (1 = trash under robot)
//   front      out drive forward
//   turn_right out rotate right
//   turn_left  out rotate left
//   remove     out trash-removal actuator
//   fault      out sticky cleaning-timeout flag
//   state_dbg  out current state encoding
module robot_controller
  import robot_pkg::*;
#(
  parameter int TURN_CYCLES = TURN_CYCLES_DEF,
  parameter int STEP_CYCLES = STEP_CYCLES_DEF,
  parameter int CLEAN_MIN   = CLEAN_MIN_DEF,
  parameter int CLEAN_MAX   = CLEAN_MAX_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       head,
  input  logic       left,
  input  logic       under,
  output logic       front,
  output logic       turn_right,
  output logic       turn_left,
  output logic       remove,
  output logic       fault,
  output logic [2:0] state_dbg
);

  localparam logic [7:0] TURN_LAST      = 8'(TURN_CYCLES - 1);
  localparam logic [7:0] STEP_LAST      = 8'(STEP_CYCLES - 1);
  localparam logic [7:0] CLEAN_MIN_LAST = 8'(CLEAN_MIN - 1);
  localparam logic [7:0] CLEAN_MAX_LAST = 8'(CLEAN_MAX - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] count;
  logic [7:0] last;
  logic       done;
  logic       front_next;
  logic       turn_right_next;
  logic       turn_left_next;
  logic       remove_next;
  logic       fault_next;

  phase_timer u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_next != state),
    .enable (is_timed(state)),
    .last   (last),
    .count  (count),
    .done   (done)
  );

  always_comb begin
    last = (state == S_STEP) ? STEP_LAST : TURN_LAST;
  end

  // Next-state logic. Trash always wins over obstacles; the obstacle is
  // picked up again from WALK once cleaning finishes.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   state_next = S_WALK;
      S_WALK: begin
        if (under)      state_next = S_CLEAN;
        else if (head)  state_next = S_TURN_R;
        else if (!left) state_next = S_TURN_L;
      end
      S_TURN_R: if (done) state_next = S_WALK;
      S_TURN_L: if (done) state_next = S_STEP;
      S_STEP: begin
        if (under)      state_next = S_CLEAN;
        else if (head)  state_next = S_TURN_R;
        else if (done)  state_next = S_WALK;
      end
      S_CLEAN: begin
        // Minimum dwell holds remove even if the trash clears early.
        if (!under && (count >= CLEAN_MIN_LAST))     state_next = S_WALK;
        else if (under && (count >= CLEAN_MAX_LAST)) state_next = S_FAULT;
      end
      S_FAULT:  state_next = S_FAULT;
      default:  state_next = S_WALK;  // unused code 7 behaves as IDLE
    endcase
  end

  // Commands decoded from the next state so they register on the same edge
  // as the state itself.
  always_comb begin
    front_next      = 1'b0;
    turn_right_next = 1'b0;
    turn_left_next  = 1'b0;
    remove_next     = 1'b0;
    fault_next      = 1'b0;
    case (state_next)
      S_WALK, S_STEP: front_next      = 1'b1;
      S_TURN_R:       turn_right_next = 1'b1;
      S_TURN_L:       turn_left_next  = 1'b1;
      S_CLEAN:        remove_next     = 1'b1;
      S_FAULT:        fault_next      = 1'b1;
      default:        ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      front      <= 1'b0;
      turn_right <= 1'b0;
      turn_left  <= 1'b0;
      remove     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_next;
      front      <= front_next;
      turn_right <= turn_right_next;
      turn_left  <= turn_left_next;
      remove     <= remove_next;
      fault      <= fault_next;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_robot_controller.sv
// Bench for robot_controller: a behavioural model tracks which activity the
// robot should be in and how long it has been doing it; every cycle the DUT
// outputs are compared against it. Directed scenarios pin run lengths with
// hand-computed literals, then random sensor traffic exercises the rest.
module tb_robot_controller;
  import robot_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       head = 1'b0;
  logic       left = 1'b0;
  logic       under = 1'b0;
  logic       front, turn_right, turn_left, remove, fault;
  logic [2:0] state_dbg;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  robot_controller dut (
    .clk        (clk),
    .reset      (reset),
    .head       (head),
    .left       (left),
    .under      (under),
    .front      (front),
    .turn_right (turn_right),
    .turn_left  (turn_left),
    .remove     (remove),
    .fault      (fault),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Activity plus number of whole cycles already spent in it.
  state_t m_mode = S_IDLE;
  int     m_spent = 0;
  state_t m_nxt;
  int     m_now;

  always @(posedge clk) begin
    m_now = m_spent + 1;  // cycles in this activity including the current one
    m_nxt = m_mode;
    if (!reset) m_nxt = S_IDLE;
    else begin
      case (m_mode)
        S_IDLE:   m_nxt = S_WALK;
        S_WALK:   m_nxt = under ? S_CLEAN : head ? S_TURN_R : !left ? S_TURN_L : S_WALK;
        S_TURN_R: if (m_now == TURN_CYCLES_DEF) m_nxt = S_WALK;
        S_TURN_L: if (m_now == TURN_CYCLES_DEF) m_nxt = S_STEP;
        S_STEP:   m_nxt = under ? S_CLEAN : head ? S_TURN_R :
                          (m_now == STEP_CYCLES_DEF) ? S_WALK : S_STEP;
        S_CLEAN: begin
          if (!under && m_now >= CLEAN_MIN_DEF)     m_nxt = S_WALK;
          else if (under && m_now >= CLEAN_MAX_DEF) m_nxt = S_FAULT;
        end
        default:  m_nxt = m_mode;
      endcase
    end
    m_spent = (!reset || m_nxt != m_mode) ? 0 : m_now;
    m_mode  = m_nxt;
  end

  // ---------------- per-cycle compare ----------------
  logic [7:0] exp_vec, got_vec;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_vec = {3'(m_mode),
                 (m_mode == S_WALK) || (m_mode == S_STEP),
                 m_mode == S_TURN_R,
                 m_mode == S_TURN_L,
                 m_mode == S_CLEAN,
                 m_mode == S_FAULT};
      got_vec = {state_dbg, front, turn_right, turn_left, remove, fault};
      total++;
      if (got_vec !== exp_vec) begin
        bad++;
        $display("FAIL model_cmp: got %b expected %b at %0t", got_vec, exp_vec, $time);
      end
      check("one_cmd", ($countones({front, turn_right, turn_left, remove}) <= 1) ? 1 : 0, 1);
    end
  end

  // ---------------- directed helpers ----------------
  function automatic logic sig(input int w);
    case (w)
      0: return front;
      1: return turn_right;
      2: return turn_left;
      3: return remove;
      default: return state_dbg == 3'd4;
    endcase
  endfunction

  // Counts consecutive negedges (starting with the current one) where the
  // selected signal is 1; returns at the first negedge where it is 0.
  task automatic run_len(input int w, output int len);
    len = 0;
    while (sig(w) === 1'b1 && len < 1000) begin
      len++;
      @(negedge clk);
    end
    if (len >= 1000) check("run_bound", len, -1);
  endtask

  int n;
  int burst;

  initial begin
    #7 chk_en = 1'b1;
    @(negedge clk);
    // Reset state
    check("rst_state", state_dbg, 0);
    check("rst_cmds", {front, turn_right, turn_left, remove, fault}, 0);

    // Release with a wall on the left: IDLE then steady WALK
    left = 1'b1; reset = 1'b1;
    check("idle_after_release", state_dbg, 0);
    @(negedge clk);
    check("walk_first", state_dbg, 1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (front === 1'b1) n++;
      @(negedge clk);
    end
    check("front_100", n, 100);

    // Obstacle pulse: 16-cycle right turn then walk
    head = 1'b1; @(negedge clk); head = 1'b0;
    run_len(1, n);
    check("turn_right_len", n, 16);
    check("front_after_tr", front, 1);

    // Lost wall: left turn, 32-cycle step, back to walk
    left = 1'b0; @(negedge clk); left = 1'b1;
    run_len(2, n);
    check("turn_left_len", n, 16);
    run_len(4, n);
    check("step_len", n, 32);
    check("walk_after_step", state_dbg, 1);

    // Obstacle in STEP cycle 10 interrupts it
    left = 1'b0; @(negedge clk); left = 1'b1;
    run_len(2, n);
    repeat (10) @(negedge clk);
    check("still_step", state_dbg, 4);
    head = 1'b1; @(negedge clk); head = 1'b0;
    check("step_to_turn_r", state_dbg, 2);
    run_len(1, n);
    check("turn_right_len2", n, 16);

    // Short trash: minimum 8 cycles of remove
    under = 1'b1; @(negedge clk);
    @(negedge clk); @(negedge clk); under = 1'b0;
    n = 2;
    run_len(3, burst);
    check("clean_min_len", n + burst, 8);

    // Long trash: remove lasts until a cycle after under falls
    under = 1'b1; @(negedge clk);
    repeat (19) @(negedge clk);
    under = 1'b0;
    run_len(3, burst);
    check("clean_20_len", burst + 19, 20);

    // Simultaneous head and under: CLEAN wins
    head = 1'b1; under = 1'b1; @(negedge clk); head = 1'b0; under = 1'b0;
    check("clean_beats_turn", state_dbg, 5);
    run_len(3, n);
    check("clean_min_len2", n, 8);

    // Stuck trash: 255 cycles of remove, then sticky fault
    under = 1'b1; @(negedge clk);
    run_len(3, n);
    check("clean_max_len", n, 255);
    check("fault_set", fault, 1);
    check("fault_cmds", {front, turn_right, turn_left, remove}, 0);
    under = 1'b0;
    repeat (5) @(negedge clk);
    check("fault_sticky", fault, 1);
    reset = 1'b0; @(negedge clk);
    check("fault_cleared", {fault, 3'(state_dbg)}, 0);
    reset = 1'b1; @(negedge clk);
    check("walk_after_fault_rst", state_dbg, 1);

    // Reset in the middle of a left turn
    left = 1'b0; @(negedge clk); left = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_turn_left", turn_left, 1);
    reset = 1'b0; @(negedge clk);
    check("rst_mid_turn", {front, turn_right, turn_left, remove, fault, state_dbg}, 0);
    reset = 1'b1;

    // Random sensor traffic, model-checked every cycle
    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      head = ($urandom_range(0, 19) == 0);
      left = ($urandom_range(0, 9) != 0);
      if (burst > 0) burst--;
      else if ($urandom_range(0, 399) == 0) burst = 260 + $urandom_range(0, 20);
      else if ($urandom_range(0, 29) == 0) burst = $urandom_range(1, 30);
      under = (burst > 0);
      reset = ($urandom_range(0, 499) != 0);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
